// File: rtl/mpp_pkg.sv
// Shared types and constants for the MPP program loader.
// Optional build macro used by the loader: MPP_PROG_CHECKSUM_EN.
package mpp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;
    localparam int         PROG_ADDR_W       = 16;

    // True when a processor fetch address lies inside a 2**addr_w byte store.
    function automatic logic addr_in_store(input logic [PROG_ADDR_W-1:0] addr,
                                           input int                     addr_w);
        logic [PROG_ADDR_W:0] limit;
        limit = {{PROG_ADDR_W{1'b0}}, 1'b1} << addr_w;
        return ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/mpp_prog_ram.sv
// Single-port synchronous program store with write enable and registered read.
// The read register resets to zero so the fetched byte starts from a known value.
module mpp_prog_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rdata_r;

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port, held when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r <= 8'h00;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mpp_prog_loader.sv
// Byte-stream program loader feeding a processor fetch port from an on-chip store.
// Define MPP_PROG_CHECKSUM_EN to treat the final loader byte as a modulo-256 checksum.
module mpp_prog_loader
    import mpp_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [7:0]             load_data,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic [PROG_ADDR_W-1:0] program_addr,
    input  logic                   program_cs_n,
    output logic [7:0]             instruction,
    output logic                   cpu_run,
    output logic                   load_err
);

    localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic              accept_s;
    logic              store_s;
    logic              overflow_s;
    logic              fetch_s;
    logic              in_range_s;
    logic              ram_we_s;
    logic              ram_re_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [7:0]        ram_rdata_s;
    logic              load_ready_r;
    logic              cpu_run_r;
    logic              load_err_r;
    logic              fill_sel_r;
    logic              next_ready_s;
    logic              next_run_s;
    logic              next_err_s;
    logic [7:0]        instruction_s;
`ifdef MPP_PROG_CHECKSUM_EN
    logic [7:0]        sum_r;
    logic              sum_ok_s;
`endif

    // Handshake, store and fetch strobes.
    always_comb begin
        accept_s = load_valid && load_ready_r;
`ifdef MPP_PROG_CHECKSUM_EN
        store_s  = accept_s && !load_last;
        sum_ok_s = (load_data == sum_r);
`else
        store_s  = accept_s;
`endif
        overflow_s = accept_s && !load_last && (wr_ptr_r == PTR_MAX);
        fetch_s    = (state_r == ST_RUN) && !program_cs_n;
        in_range_s = addr_in_store(program_addr, ADDR_W);
        ram_we_s   = store_s;
        ram_re_s   = fetch_s && in_range_s;
        // One port: the loader owns the address until RUN, the processor afterwards.
        if (state_r == ST_RUN) begin
            ram_addr_s = program_addr[ADDR_W-1:0];
        end else begin
            ram_addr_s = wr_ptr_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; RUN and ERROR are left only through reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (!accept_s) begin
                    next_state_s = state_r;
                end else if (load_last) begin
`ifdef MPP_PROG_CHECKSUM_EN
                    if (sum_ok_s) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_ERROR;
                    end
`else
                    next_state_s = ST_RUN;
`endif
                end else if (overflow_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RUN:   next_state_s = ST_RUN;
            ST_ERROR: next_state_s = ST_ERROR;
            default:  next_state_s = ST_ERROR;
        endcase
    end

    // FSM output decode, computed from the next state so the outputs are registered.
    always_comb begin
        next_ready_s = 1'b0;
        next_run_s   = 1'b0;
        next_err_s   = 1'b0;
        case (next_state_s)
            ST_IDLE:  next_ready_s = 1'b1;
            ST_LOAD:  next_ready_s = 1'b1;
            ST_RUN:   next_run_s   = 1'b1;
            ST_ERROR: next_err_s   = 1'b1;
            default:  next_err_s   = 1'b1;
        endcase
    end

    // Status output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready_r <= 1'b1;
            cpu_run_r    <= 1'b0;
            load_err_r   <= 1'b0;
        end else begin
            load_ready_r <= next_ready_s;
            cpu_run_r    <= next_run_s;
            load_err_r   <= next_err_s;
        end
    end

    // Write pointer; parks at the top address instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
        end else if (store_s && (wr_ptr_r != PTR_MAX)) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
    end

`ifdef MPP_PROG_CHECKSUM_EN
    // Running modulo-256 sum of every stored program byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 8'h00;
        end else if (store_s) begin
            sum_r <= sum_r + load_data;
        end
    end
`endif

    // Remembers whether the latest fetch fell outside the store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_sel_r <= 1'b0;
        end else if (fetch_s) begin
            fill_sel_r <= !in_range_s;
        end
    end

    mpp_prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (load_data),
        .rdata (ram_rdata_s)
    );

    // Instruction byte: both sources are flops, so the byte only moves on a fetch edge.
    always_comb begin
        if (fill_sel_r) begin
            instruction_s = FILL_BYTE;
        end else begin
            instruction_s = ram_rdata_s;
        end
    end

    assign instruction = instruction_s;
    assign load_ready  = load_ready_r;
    assign cpu_run     = cpu_run_r;
    assign load_err    = load_err_r;

endmodule

// File: doc/mpp_prog_loader.md
MPP_PROG_LOADER -- requirements
Module: mpp_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets program store depth to 2**ADDR_W bytes.
REQ-002 Parameter FILL_BYTE, default 8'h00, is the byte returned for fetches outside the store.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 load_valid  input  1  loader byte valid.
REQ-006 load_data  input  8  loader byte.
REQ-007 load_last  input  1  marks the final loader byte; qualified by load_valid.
REQ-008 load_ready  output  1  store accepts a loader byte this cycle.
REQ-009 program_addr  input  16  processor fetch address.
REQ-010 program_cs_n  input  1  active-low fetch strobe from the processor's out_signals[1] (inverted).
REQ-011 instruction  output  8  registered instruction byte to the processor.
REQ-012 cpu_run  output  1  program loaded; processor may execute.
REQ-013 load_err  output  1  load aborted; sticky until reset.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN and ERROR.
REQ-015 IDLE: load_ready=1; an accepted byte (load_valid & load_ready) SHALL be written at wr_ptr=0 and move the FSM to LOAD, or to RUN if load_last=1.
REQ-016 LOAD: load_ready=1; each accepted byte SHALL be written at wr_ptr, and wr_ptr SHALL increment by 1.
REQ-017 An accepted byte with load_last=1 SHALL move the FSM to RUN on the same edge.
REQ-018 An accepted byte at wr_ptr=2**ADDR_W-1 with load_last=0 SHALL be stored, and the FSM SHALL enter ERROR with load_err=1; wr_ptr SHALL NOT wrap.
REQ-019 RUN and ERROR: load_ready=0; load_valid SHALL be ignored.
REQ-020 cpu_run SHALL be 1 only in RUN.
REQ-021 RUN: with program_cs_n=0 at a rising edge, instruction SHALL update on that edge (one-cycle latency) to store[program_addr[ADDR_W-1:0]] if program_addr < 2**ADDR_W, else FILL_BYTE.
REQ-022 With program_cs_n=1, or in any state other than RUN, instruction SHALL hold its value.
REQ-023 Consecutive cycles with program_cs_n=0 SHALL each return a new fetch (full throughput).
REQ-024 Only reset SHALL leave RUN or ERROR.

Reset
REQ-025 rst=1 SHALL immediately force: FSM=IDLE, wr_ptr=0, instruction=8'h00, cpu_run=0, load_err=0, load_ready=1 (from the start of the first cycle after release).
REQ-026 Store contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted mid-LOAD SHALL discard the partial load; the next load restarts at address 0.

Configuration
REQ-028 With MPP_PROG_CHECKSUM_EN defined:
- the byte carrying load_last SHALL be a checksum and SHALL NOT be stored;
- the module SHALL keep a modulo-256 sum of all stored bytes;
- a checksum that matches the sum SHALL move the FSM to RUN;
- a mismatch SHALL move the FSM to ERROR with load_err=1.
REQ-029 With MPP_PROG_CHECKSUM_EN defined, a load_last byte accepted in IDLE SHALL be checked against a sum of 0.
REQ-030 Without MPP_PROG_CHECKSUM_EN, the load_last byte SHALL be stored as program data, and no sum logic SHALL exist.

Structure
REQ-031 Shared package mpp_pkg SHALL hold the FSM state enum, the default FILL_BYTE constant and the 16-bit program address width.
REQ-032 Storage SHALL be a sub-module mpp_prog_ram: single-port synchronous RAM, 2**ADDR_W x 8, with write enable and registered read. Writes occur only in IDLE/LOAD and reads only in RUN, so one port suffices.

Verification
REQ-033 Load 07,C0,44,C1,CB (last on CB), then fetch addr 0x0003 with cs_n=0 -> cpu_run=1 after CB; instruction=C1 one edge later.
REQ-034 In RUN, fetch 0x0100 -> instruction=00; then hold cs_n=1 for 3 cycles -> instruction stays 00.
REQ-035 Stream 256 bytes without load_last -> load_err=1 and load_ready=0 after byte 256, cpu_run=0; a 257th load_valid is ignored.
REQ-036 With MPP_PROG_CHECKSUM_EN: load 07,C0 then checksum C7 -> RUN, and fetch 0x0002 returns FILL_BYTE-independent store data; checksum C8 instead -> ERROR, load_err=1.
REQ-037 Assert rst after 3 of 5 bytes, release, then load 03,00 (last) -> outputs zero during reset; RUN after 00; fetch 0x0000 -> 03.
REQ-038 Back-to-back fetches 0x0000..0x0004 with cs_n held low -> 07,C0,44,C1,CB on successive edges.
